phase_sequencer: RTL and testbench

//  Timing master for the crossing: steps cur_phase through 0->1->2->3->4->0 and

---
 rtl/phase_sequencer.sv | 124 ++++++++++++
 tb/tb_phase_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Crossing timing master: walks cur_phase 0..4, counts each phase down in whole
// seconds and emits a one-cycle minus_1 pulse per second tick.
module phase_sequencer #(
   parameter int unsigned TICK_DIV = 25000000,
   parameter int unsigned PH0_SEC  = 5,
   parameter int unsigned PH1_SEC  = 3,
   parameter int unsigned PH2_SEC  = 9,
   parameter int unsigned PH3_SEC  = 3,
   parameter int unsigned PH4_SEC  = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause,
   input  logic       skip,
   output logic [2:0] cur_phase,
   output logic [3:0] seven_num,
   output logic       minus_1
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   // Durations must fit one display digit and never be zero.
   function automatic logic [3:0] sat_dur(input int unsigned sec);
      if (sec == 0) begin
         return 4'd1;
      end else if (sec > 9) begin
         return 4'd9;
      end
      return 4'(sec);
   endfunction

   localparam logic [3:0] Dur0 = sat_dur(PH0_SEC);
   localparam logic [3:0] Dur1 = sat_dur(PH1_SEC);
   localparam logic [3:0] Dur2 = sat_dur(PH2_SEC);
   localparam logic [3:0] Dur3 = sat_dur(PH3_SEC);
   localparam logic [3:0] Dur4 = sat_dur(PH4_SEC);

   function automatic logic [3:0] dur_of(input logic [2:0] ph);
      case (ph)
         3'd1:    return Dur1;
         3'd2:    return Dur2;
         3'd3:    return Dur3;
         3'd4:    return Dur4;
         default: return Dur0;
      endcase
   endfunction

   // StSync spends one edge after reset release before anything counts.
   typedef enum logic {StSync, StRun} state_e;

   state_e            r_state, w_state;
   logic [2:0]        r_phase, w_phase;
   logic [3:0]        r_sec, w_sec;
   logic [CntW-1:0]   r_cnt, w_cnt;
   logic              r_minus, w_minus;
   logic              w_tick;
   logic [2:0]        w_adv_phase;

   assign w_tick      = (r_cnt == CntMax);
   assign w_adv_phase = (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;

   always_comb begin
      w_state = r_state;
      w_phase = r_phase;
      w_sec   = r_sec;
      w_cnt   = r_cnt;
      w_minus = 1'b0;
      unique case (r_state)
         StSync: begin
            w_state = StRun;
         end
         StRun: begin
            if (r_phase > 3'd4) begin
               w_phase = 3'd0;
               w_sec   = Dur0;
               w_cnt   = '0;
            end else if (skip) begin
               // Skip wins over a coincident tick and suppresses its pulse.
               w_phase = w_adv_phase;
               w_sec   = dur_of(w_adv_phase);
               w_cnt   = '0;
            end else if (!pause) begin
               if (w_tick) begin
                  w_cnt   = '0;
                  w_minus = 1'b1;
                  if (r_sec > 4'd1) begin
                     w_sec = r_sec - 4'd1;
                  end else begin
                     w_phase = w_adv_phase;
                     w_sec   = dur_of(w_adv_phase);
                  end
               end else begin
                  w_cnt = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state = StSync;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StSync;
         r_phase <= 3'd0;
         r_sec   <= Dur0;
         r_cnt   <= '0;
         r_minus <= 1'b0;
      end else begin
         r_state <= w_state;
         r_phase <= w_phase;
         r_sec   <= w_sec;
         r_cnt   <= w_cnt;
         r_minus <= w_minus;
      end
   end

   assign cur_phase = r_phase;
   assign seven_num = r_sec;
   assign minus_1   = r_minus;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized bench for phase_sequencer against a second-granular behavioural
// model of the crossing timing rules.
module tb_phase_sequencer;

   localparam int unsigned TickDiv = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pause = 1'b0;
   logic       skip = 1'b0;
   logic [2:0] cur_phase;
   logic [3:0] seven_num;
   logic       minus_1;

   int checks = 0;
   int errors = 0;

   // Reference state: phase, seconds left, clocks into current second.
   int m_phase;
   int m_sec;
   int m_cnt;
   bit m_run;
   bit m_minus;
   int dur[5] = '{5, 3, 9, 3, 7};

   phase_sequencer #(
      .TICK_DIV(TickDiv),
      .PH0_SEC (5),
      .PH1_SEC (3),
      .PH2_SEC (9),
      .PH3_SEC (3),
      .PH4_SEC (7)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pause    (pause),
      .skip     (skip),
      .cur_phase(cur_phase),
      .seven_num(seven_num),
      .minus_1  (minus_1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required finish before 200000");
      $fatal(1);
   end

   function automatic void model_reset();
      m_phase = 0;
      m_sec   = dur[0];
      m_cnt   = 0;
      m_run   = 1'b0;
      m_minus = 1'b0;
   endfunction

   function automatic void model_advance();
      m_phase = (m_phase + 1) % 5;
      m_sec   = dur[m_phase];
   endfunction

   function automatic void model_step(input bit p, input bit s);
      m_minus = 1'b0;
      if (!m_run) begin
         m_run = 1'b1;
      end else if (m_phase > 4) begin
         m_phase = 0;
         m_sec   = dur[0];
         m_cnt   = 0;
      end else if (s) begin
         model_advance();
         m_cnt = 0;
      end else if (!p) begin
         m_cnt = m_cnt + 1;
         if (m_cnt == TickDiv) begin
            m_cnt   = 0;
            m_minus = 1'b1;
            if (m_sec == 1) model_advance();
            else m_sec = m_sec - 1;
         end
      end
   endfunction

   // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
   task automatic step(input bit p, input bit s);
      pause = p;
      skip  = s;
      model_step(p, s);
      @(posedge clk);
      #1;
      skip = 1'b0;
   endtask

   // Async reset asserted mid-cycle, released before the next edge.
   task automatic pulse_reset();
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      checks += 3;
      if (cur_phase !== 3'd0) begin
         errors++;
         $display("FAIL reset_phase: got %0d want 0", cur_phase);
      end
      if (seven_num !== 4'd5) begin
         errors++;
         $display("FAIL reset_sec: got %0d want 5", seven_num);
      end
      if (minus_1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_minus: got %0b want 0", minus_1);
      end
      rst = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 1'b0);
         checks += 2;
         if (minus_1 !== (i == 5)) begin
            errors++;
            $display("FAIL release_minus edge %0d: got %0b want %0b", i, minus_1, (i == 5));
         end
         if (seven_num !== ((i >= 5) ? 4'd4 : 4'd5)) begin
            errors++;
            $display("FAIL release_sec edge %0d: got %0d want %0d", i, seven_num,
                     (i >= 5) ? 4 : 5);
         end
      end
   endtask

   task automatic test_free_run();
      int pulses;
      pulses = 0;
      pulse_reset();
      for (int i = 0; i < 1 + 27 * TickDiv; i++) begin
         step(1'b0, 1'b0);
         if (minus_1 === 1'b1) pulses++;
         checks++;
         if (cur_phase !== 3'(m_phase) || seven_num !== 4'(m_sec) || minus_1 !== m_minus) begin
            errors++;
            $display("FAIL free_run cyc %0d: got %0d/%0d/%0b want %0d/%0d/%0b", i, cur_phase,
                     seven_num, minus_1, m_phase, m_sec, m_minus);
         end
      end
      checks += 2;
      if (pulses != 27) begin
         errors++;
         $display("FAIL free_run_pulses: got %0d want 27", pulses);
      end
      if (cur_phase !== 3'd0 || seven_num !== 4'd5) begin
         errors++;
         $display("FAIL free_run_wrap: got %0d/%0d want 0/5", cur_phase, seven_num);
      end
   endtask

   task automatic test_pause();
      int snap_phase;
      int snap_sec;
      for (int i = 0; i < 8 && m_cnt != 2; i++) step(1'b0, 1'b0);
      checks++;
      if (m_cnt != 2) begin
         errors++;
         $display("FAIL pause_setup: got cnt %0d want 2", m_cnt);
      end
      snap_phase = m_phase;
      snap_sec   = m_sec;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0);
         checks++;
         if (cur_phase !== 3'(snap_phase) || seven_num !== 4'(snap_sec) || minus_1 !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold cyc %0d: got %0d/%0d/%0b want %0d/%0d/0", i, cur_phase,
                     seven_num, minus_1, snap_phase, snap_sec);
         end
      end
      for (int i = 1; i <= 2; i++) begin
         step(1'b0, 1'b0);
         checks++;
         if (minus_1 !== (i == 2)) begin
            errors++;
            $display("FAIL pause_resume edge %0d: got %0b want %0b", i, minus_1, (i == 2));
         end
      end
   endtask

   task automatic test_skip();
      int edges;
      for (int i = 0; i < 200 && !(m_phase == 2 && m_sec == 6); i++) step(1'b0, 1'b0);
      checks++;
      if (!(m_phase == 2 && m_sec == 6)) begin
         errors++;
         $display("FAIL skip_setup: got %0d/%0d want 2/6", m_phase, m_sec);
      end
      step(1'b0, 1'b1);
      checks++;
      if (cur_phase !== 3'd3 || seven_num !== 4'd3 || minus_1 !== 1'b0) begin
         errors++;
         $display("FAIL skip_advance: got %0d/%0d/%0b want 3/3/0", cur_phase, seven_num, minus_1);
      end
      edges = 1;
      while (minus_1 !== 1'b1 && edges < 12) begin
         step(1'b0, 1'b0);
         edges++;
      end
      checks++;
      if (edges != TickDiv + 1) begin
         errors++;
         $display("FAIL skip_restart: got pulse at edge %0d want %0d", edges, TickDiv + 1);
      end
   endtask

   task automatic test_skip_tick();
      for (int i = 0; i < 200 && !(m_phase == 4 && m_sec == 1 && m_cnt == TickDiv - 1); i++)
         step(1'b0, 1'b0);
      checks++;
      if (!(m_phase == 4 && m_sec == 1 && m_cnt == TickDiv - 1)) begin
         errors++;
         $display("FAIL skip_tick_setup: got %0d/%0d/%0d want 4/1/%0d", m_phase, m_sec, m_cnt,
                  TickDiv - 1);
      end
      step(1'b0, 1'b1);
      checks++;
      if (cur_phase !== 3'd0 || seven_num !== 4'd5 || minus_1 !== 1'b0) begin
         errors++;
         $display("FAIL skip_tick: got %0d/%0d/%0b want 0/5/0", cur_phase, seven_num, minus_1);
      end
      step(1'b0, 1'b0);
      checks++;
      if (cur_phase !== 3'd0 || seven_num !== 4'd5 || minus_1 !== 1'b0) begin
         errors++;
         $display("FAIL skip_tick_after: got %0d/%0d/%0b want 0/5/0", cur_phase, seven_num,
                  minus_1);
      end
   endtask

   task automatic test_upset();
      step(1'b0, 1'b0);
      force dut.r_phase = 3'd6;
      #1;
      release dut.r_phase;
      checks++;
      if (cur_phase !== 3'd6) begin
         errors++;
         $display("FAIL upset_deposit: got %0d want 6", cur_phase);
      end
      m_phase = 6;
      step(1'b0, 1'b0);
      checks++;
      if (cur_phase !== 3'd0 || seven_num !== 4'd5 || minus_1 !== 1'b0) begin
         errors++;
         $display("FAIL upset_recover: got %0d/%0d/%0b want 0/5/0", cur_phase, seven_num,
                  minus_1);
      end
      for (int i = 1; i <= TickDiv; i++) begin
         step(1'b0, 1'b0);
         checks++;
         if (minus_1 !== (i == TickDiv)) begin
            errors++;
            $display("FAIL upset_cnt edge %0d: got %0b want %0b", i, minus_1, (i == TickDiv));
         end
      end
   endtask

   task automatic test_random();
      bit p;
      bit s;
      p = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0) p = ~p;
         s = ($urandom_range(15) == 0);
         step(p, s);
         checks++;
         if (cur_phase !== 3'(m_phase) || seven_num !== 4'(m_sec) || minus_1 !== m_minus) begin
            errors++;
            $display("FAIL random cyc %0d: got %0d/%0d/%0b want %0d/%0d/%0b", i, cur_phase,
                     seven_num, minus_1, m_phase, m_sec, m_minus);
         end
      end
      pause = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      test_reset();
      test_free_run();
      test_pause();
      test_skip();
      test_skip_tick();
      test_upset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
